// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the user_io SD sector port between NREQ drive requesters.
// One sector transfer at a time; ack-less requests are aborted after TIMEOUT cycles.
module sd_req_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 24'hFFFFFF
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [NREQ-1:0]      req_gnt,
  output logic [NREQ-1:0]      buff_wr,
  input  logic [8*NREQ-1:0]    buff_din,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [7:0]           sd_buff_din
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RELEASE} state_t;

  state_t          state, state_n;
  logic            ack_m, ack_s;
  logic [PW-1:0]   ptr, ptr_n;
  logic [TW-1:0]   timer, timer_n;
  logic [31:0]     lba_n;
  logic            rd_n, wr_n;
  logic [NREQ-1:0] gnt_n, done_n, err_n;
  logic [NREQ-1:0] active;
  logic            found;
  logic [PW-1:0]   pick, cand;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    timer_n = timer;
    lba_n   = sd_lba;
    rd_n    = sd_rd;
    wr_n    = sd_wr;
    gnt_n   = req_gnt;
    done_n  = '0;
    err_n   = '0;
    active  = req_rd | req_wr;
    found   = 1'b0;
    pick    = '0;
    cand    = '0;

    // First active requester after the last winner, wrapping mod NREQ.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = PW'((32'(ptr) + k) % NREQ);
      if (!found && active[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state)
      S_IDLE: begin
        if (found && !ack_s) begin
          lba_n   = req_lba[{pick, 5'd0} +: 32];
          gnt_n   = NREQ'(1) << pick;
          ptr_n   = pick;
          wr_n    = req_wr[pick];
          rd_n    = req_rd[pick] & ~req_wr[pick];
          timer_n = '0;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          timer_n = '0;
          state_n = S_XFER;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          timer_n = '0;
          err_n   = req_gnt;
          state_n = S_RELEASE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_XFER: begin
        if (!ack_s) begin
          done_n  = req_gnt;
          state_n = S_RELEASE;
        end
      end
      S_RELEASE: begin
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= S_IDLE;
      ack_m    <= 1'b0;
      ack_s    <= 1'b0;
      ptr      <= PW'(NREQ - 1);
      timer    <= '0;
      sd_lba   <= '0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      req_gnt  <= '0;
      req_done <= '0;
      req_err  <= '0;
    end else begin
      state    <= state_n;
      ack_m    <= sd_ack;
      ack_s    <= ack_m;
      ptr      <= ptr_n;
      timer    <= timer_n;
      sd_lba   <= lba_n;
      sd_rd    <= rd_n;
      sd_wr    <= wr_n;
      req_gnt  <= gnt_n;
      req_done <= done_n;
      req_err  <= err_n;
    end
  end

  assign buff_wr = {NREQ{sd_buff_wr}} & req_gnt;

  always_comb begin
    sd_buff_din = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      sd_buff_din = sd_buff_din | (buff_din[8*i +: 8] & {8{req_gnt[i]}});
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: vector table, directed corner sequences,
// and randomized transactions against a round-robin transaction model.
module tb_sd_req_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int unsigned TO   = 16;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_rd, req_wr;
  logic [32*NREQ-1:0] req_lba;
  logic [NREQ-1:0]   req_done, req_err, req_gnt, buff_wr;
  logic [8*NREQ-1:0] buff_din;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr;
  logic              sd_ack, sd_buff_wr;
  logic [7:0]        sd_buff_din;

  int checks = 0;
  int errors = 0;

  sd_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .req_done(req_done), .req_err(req_err), .req_gnt(req_gnt),
    .buff_wr(buff_wr), .buff_din(buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req_rd = '0; req_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!(sd_rd | sd_wr) && n < 20) begin tick; n++; end
    check({name, "_busy"}, 64'(sd_rd | sd_wr), 64'd1);
  endtask

  task automatic wait_pulse(output logic [NREQ-1:0] d, output logic [NREQ-1:0] e);
    int n = 0;
    while ((req_done | req_err) == '0 && n < 40) begin tick; n++; end
    d = req_done;
    e = req_err;
  endtask

  task automatic serve(input string name, input logic [NREQ-1:0] exp_done);
    logic [NREQ-1:0] d, e;
    sd_ack = 1'b1;
    repeat (6) tick;
    sd_ack = 1'b0;
    wait_pulse(d, e);
    check({name, "_done"}, 64'(d), 64'(exp_done));
    check({name, "_err"},  64'(e), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] lba0, lba1;
    logic        exp_rd, exp_wr;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_lba;
  } vec_t;

  vec_t vecs[7];

  // Transaction-level model state: last winner index.
  int ptr_m;

  task automatic add_req(input int i);
    int kind;
    kind = int'($urandom_range(0, 2));
    req_lba[32*i +: 32] = $urandom;
    req_rd[i] = (kind != 1);
    req_wr[i] = (kind != 0);
  endtask

  initial begin
    logic [NREQ-1:0] d, e;
    int cnt0, cnt1, bad, w, timeout_case;
    bit found;
    logic [31:0] exp_lba;
    logic exp_rd, exp_wr;

    buff_din = '0; req_lba = '0;

    // Reset wins over pending requests
    reset = 1'b1; req_rd = 2'b11; req_wr = 2'b00; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick; tick;
    check("rst_rd", 64'(sd_rd), 0); check("rst_wr", 64'(sd_wr), 0);
    check("rst_lba", 64'(sd_lba), 0); check("rst_gnt", 64'(req_gnt), 0);
    check("rst_done", 64'(req_done), 0); check("rst_err", 64'(req_err), 0);

    vecs[0] = '{2'b01, 2'b00, 32'h0000_1234, 32'hAAAA_0001, 1'b1, 1'b0, 2'b01, 32'h0000_1234};
    vecs[1] = '{2'b10, 2'b00, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b10, 32'hDEAD_BEEF};
    vecs[2] = '{2'b01, 2'b01, 32'h0000_0077, 32'h0000_0088, 1'b0, 1'b1, 2'b01, 32'h0000_0077};
    vecs[3] = '{2'b00, 2'b10, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 2'b10, 32'h2222_2222};
    vecs[4] = '{2'b11, 2'b00, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 2'b01, 32'h0000_0100};
    vecs[5] = '{2'b10, 2'b01, 32'h0000_0300, 32'h0000_0400, 1'b0, 1'b1, 2'b01, 32'h0000_0300};
    vecs[6] = '{2'b00, 2'b00, 32'h0000_0500, 32'h0000_0600, 1'b0, 1'b0, 2'b00, 32'h0000_0000};

    foreach (vecs[v]) begin
      do_reset;
      req_lba = {vecs[v].lba1, vecs[v].lba0};
      req_rd = vecs[v].rd; req_wr = vecs[v].wr;
      #1;
      check($sformatf("v%0d_pre_busy", v), 64'(sd_rd | sd_wr), 0);
      tick;
      check($sformatf("v%0d_rd", v),  64'(sd_rd),   64'(vecs[v].exp_rd));
      check($sformatf("v%0d_wr", v),  64'(sd_wr),   64'(vecs[v].exp_wr));
      check($sformatf("v%0d_gnt", v), 64'(req_gnt), 64'(vecs[v].exp_gnt));
      check($sformatf("v%0d_lba", v), 64'(sd_lba),  64'(vecs[v].exp_lba));
    end

    // Single read: done exactly 3 cycles after ack falls
    do_reset;
    req_lba = {32'h0, 32'h0000_1234}; req_rd = 2'b01;
    tick;
    check("t1_rd", 64'(sd_rd), 1); check("t1_lba", 64'(sd_lba), 64'h1234);
    sd_ack = 1'b1;
    repeat (5) tick;
    check("t1_rd_drop", 64'(sd_rd), 0); check("t1_gnt_xfer", 64'(req_gnt), 64'b01);
    repeat (15) tick;
    sd_ack = 1'b0;
    tick; check("t1_done_c1", 64'(req_done), 0);
    tick; check("t1_done_c2", 64'(req_done), 0);
    tick; check("t1_done_c3", 64'(req_done), 64'b01); check("t1_err", 64'(req_err), 0);
    req_rd = 2'b00;
    tick; check("t1_done_clr", 64'(req_done), 0); check("t1_gnt_clr", 64'(req_gnt), 0);

    // Contention and pointer wrap
    do_reset;
    req_lba = {32'h0000_0B0B, 32'h0000_0A0A}; req_rd = 2'b11;
    tick;
    check("t2_gnt_a", 64'(req_gnt), 64'b01); check("t2_lba_a", 64'(sd_lba), 64'h0A0A);
    serve("t2_a", 2'b01);
    req_rd[0] = 1'b0;
    wait_busy("t2_b");
    check("t2_gnt_b", 64'(req_gnt), 64'b10); check("t2_lba_b", 64'(sd_lba), 64'h0B0B);
    serve("t2_b", 2'b10);
    req_rd = 2'b01;
    tick;
    req_rd = 2'b11;
    wait_busy("t2_c");
    check("t2_gnt_c", 64'(req_gnt), 64'b01);
    serve("t2_c", 2'b01);
    req_rd = 2'b00;
    tick; tick; tick;

    // Write routing: 512 buffer strobes go only to requester 1
    do_reset;
    req_lba = {32'h0000_4000, 32'h0}; req_wr = 2'b10;
    tick;
    check("t3_wr", 64'(sd_wr), 1); check("t3_gnt", 64'(req_gnt), 64'b10);
    sd_ack = 1'b1;
    repeat (4) tick;
    cnt0 = 0; cnt1 = 0; bad = 0;
    for (int i = 0; i < 512; i++) begin
      buff_din = 16'($urandom); sd_buff_wr = 1'b1;
      #1;
      cnt0 += int'(buff_wr[0]); cnt1 += int'(buff_wr[1]);
      if (sd_buff_din !== buff_din[15:8]) bad++;
      tick;
      sd_buff_wr = 1'b0;
      #1;
      cnt0 += int'(buff_wr[0]); cnt1 += int'(buff_wr[1]);
      tick;
    end
    check("t3_buff_wr1", 64'(cnt1), 512);
    check("t3_buff_wr0", 64'(cnt0), 0);
    check("t3_din_bad", 64'(bad), 0);
    sd_ack = 1'b0;
    wait_pulse(d, e);
    check("t3_done", 64'(d), 64'b10);
    req_wr = 2'b00;
    tick; tick;
    buff_din = 16'hA55A;
    #1;
    check("t3_din_idle", 64'(sd_buff_din), 0);

    // Timeout: no ack
    do_reset;
    req_lba = {32'h0000_0999, 32'h0}; req_rd = 2'b10;
    cnt0 = 0;
    tick;
    while (sd_rd && cnt0 < 100) begin cnt0++; tick; end
    check("t5_rd_cycles", 64'(cnt0), 64'(TO));
    check("t5_err", 64'(req_err), 64'b10);
    check("t5_done", 64'(req_done), 0);
    req_rd = 2'b00;
    tick;
    check("t5_err_clr", 64'(req_err), 0); check("t5_gnt_clr", 64'(req_gnt), 0);

    // Reset during XFER
    do_reset;
    req_lba = {32'h0000_0222, 32'h0000_0111}; req_rd = 2'b01;
    tick;
    sd_ack = 1'b1;
    repeat (5) tick;
    check("t6_in_xfer_gnt", 64'(req_gnt), 64'b01);
    reset = 1'b1; req_rd = 2'b00;
    tick;
    check("t6_rd", 64'(sd_rd), 0); check("t6_gnt", 64'(req_gnt), 0);
    reset = 1'b0; sd_ack = 1'b0;
    cnt0 = 0;
    repeat (6) begin tick; if (req_done != '0) cnt0++; end
    check("t6_no_done", 64'(cnt0), 0);
    req_rd = 2'b10;
    wait_busy("t6_fresh");
    check("t6_fresh_gnt", 64'(req_gnt), 64'b10); check("t6_fresh_lba", 64'(sd_lba), 64'h222);
    serve("t6_fresh", 2'b10);
    req_rd = 2'b00;
    tick; tick;

    // Randomized transactions against the round-robin model
    do_reset;
    ptr_m = NREQ - 1;
    for (int r = 0; r < 40; r++) begin
      if ((req_rd | req_wr) == '0) add_req(int'($urandom_range(0, NREQ - 1)));
      found = 0; w = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (ptr_m + k) % NREQ;
        if (!found && (req_rd[i] | req_wr[i])) begin found = 1; w = i; end
      end
      exp_lba = req_lba[32*w +: 32];
      exp_wr  = req_wr[w];
      exp_rd  = req_rd[w] & ~req_wr[w];
      ptr_m   = w;
      wait_busy($sformatf("r%0d", r));
      check($sformatf("r%0d_gnt", r), 64'(req_gnt), 64'(1 << w));
      check($sformatf("r%0d_lba", r), 64'(sd_lba), 64'(exp_lba));
      check($sformatf("r%0d_rd", r),  64'(sd_rd), 64'(exp_rd));
      check($sformatf("r%0d_wr", r),  64'(sd_wr), 64'(exp_wr));
      timeout_case = ($urandom_range(0, 3) == 0) ? 1 : 0;
      if (timeout_case == 0) begin
        repeat ($urandom_range(0, 6)) tick;
        sd_ack = 1'b1;
        repeat ($urandom_range(3, 10)) begin
          tick;
          sd_buff_wr = 1'($urandom); buff_din = 16'($urandom);
          #1;
          check($sformatf("r%0d_buff_wr", r), 64'(buff_wr), sd_buff_wr ? 64'(1 << w) : 64'd0);
          check($sformatf("r%0d_buff_din", r), 64'(sd_buff_din), 64'(buff_din[8*w +: 8]));
        end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
      end
      wait_pulse(d, e);
      check($sformatf("r%0d_done", r), 64'(d), timeout_case ? 64'd0 : 64'(1 << w));
      check($sformatf("r%0d_err", r),  64'(e), timeout_case ? 64'(1 << w) : 64'd0);
      req_rd[w] = 1'b0; req_wr[w] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (i != w && !(req_rd[i] | req_wr[i]) && $urandom_range(0, 1) == 1) add_req(i);
      tick;
      if ($urandom_range(0, 1) == 1) add_req(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
